// File: rtl/lc3b_types.sv
// Shared LC-3b types: machine word, pipeline control word, MEM-stage states.
package lc3b_types;

  typedef logic [15:0] lc3b_word;

  // Subset of the EX/MEM control word that the MEM stage consumes.
  typedef struct packed {
    logic       is_nop;
    logic       mem_read;
    logic       mem_write;
    logic       indirect_enable;
    logic [1:0] mem_byte_enable;
  } lc3b_control_word;

  typedef enum logic [1:0] {
    mem_idle = 2'd0,
    mem_ind  = 2'd1,
    mem_acc  = 2'd2,
    mem_done = 2'd3
  } lc3b_mem_state;

  // Word accesses ignore the low address bit.
  function automatic lc3b_word word_align(input lc3b_word a);
    return {a[15:1], 1'b0};
  endfunction

endpackage

// File: rtl/mem_access_unit.sv
// MEM-stage sequencer: issues data-memory accesses (including the two-access
// indirect sequence), stalls the pipeline until data returns, and hands load
// data plus a completion pulse to the MEM/WB register.
//
// Memory handshake: an access is presented by holding dmem_read or dmem_write
// high together with a stable address/wdata/byte-enable; the memory completes
// it by raising dmem_resp for one cycle, at which point the unit either issues
// the next access on the same edge or drops the strobes. dmem_resp seen while
// no access is outstanding is ignored.
module mem_access_unit
  import lc3b_types::*;
#(
  parameter int TIMEOUT_CYCLES = 0,
  parameter int CNT_WIDTH      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stage_valid,
  input  lc3b_control_word ctrl_in,
  input  logic [15:0]      addr_in,
  input  logic [15:0]      wdata_in,
  input  logic             dmem_resp,
  input  logic [15:0]      dmem_rdata,
  output logic             dmem_read,
  output logic             dmem_write,
  output logic [15:0]      dmem_address,
  output logic [15:0]      dmem_wdata,
  output logic [1:0]       dmem_byte_enable,
  output logic [15:0]      mem_rdata_out,
  output logic             mem_done,
  output logic             stall,
  output logic             timeout_err,
  output logic [1:0]       state_dbg
);

  localparam bit                   WD_EN  = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_WIDTH-1:0] WD_LIM = CNT_WIDTH'(TIMEOUT_CYCLES);

  lc3b_mem_state        state, state_n;
  logic [CNT_WIDTH-1:0] cnt, cnt_n, cnt_sat;
  logic                 rd_n, wr_n, terr_n, wd_expire;
  logic [15:0]          addr_n, wdata_n, rdata_n;
  logic [1:0]           be_n;
  logic                 mem_op;
  logic                 ctrl_wr, ctrl_rd;

  assign mem_op = stage_valid & ~ctrl_in.is_nop & (ctrl_in.mem_read | ctrl_in.mem_write);

  // A word with both read and write set is treated as a store.
  assign ctrl_wr = ctrl_in.mem_write;
  assign ctrl_rd = ctrl_in.mem_read & ~ctrl_in.mem_write;

  assign mem_done  = (state == lc3b_types::mem_done);
  assign stall     = ((state == mem_idle) & mem_op) | (state == mem_ind) | (state == mem_acc);
  assign state_dbg = state;

  // Next state, next registered memory-port values and watchdog counter.
  always_comb begin
    state_n   = state;
    rd_n      = dmem_read;
    wr_n      = dmem_write;
    addr_n    = dmem_address;
    wdata_n   = dmem_wdata;
    be_n      = dmem_byte_enable;
    rdata_n   = mem_rdata_out;
    terr_n    = timeout_err;
    cnt_n     = cnt;
    cnt_sat   = (cnt == {CNT_WIDTH{1'b1}}) ? cnt : cnt + 1'b1;
    wd_expire = WD_EN && (cnt_sat >= WD_LIM);

    case (state)
      mem_idle: begin
        rd_n = 1'b0;
        wr_n = 1'b0;
        if (mem_op) begin
          cnt_n = '0;
          if (ctrl_in.indirect_enable) begin
            state_n = mem_ind;
            rd_n    = 1'b1;
            addr_n  = word_align(addr_in);
            be_n    = 2'b11;
          end else begin
            state_n = mem_acc;
            rd_n    = ctrl_rd;
            wr_n    = ctrl_wr;
            addr_n  = addr_in;
            be_n    = ctrl_in.mem_byte_enable;
            wdata_n = wdata_in;
          end
        end
      end

      mem_ind: begin
        if (dmem_resp) begin
          // Chain straight into the final access; strobes stay high.
          state_n = mem_acc;
          cnt_n   = '0;
          rd_n    = ctrl_rd;
          wr_n    = ctrl_wr;
          addr_n  = word_align(dmem_rdata);
          be_n    = ctrl_in.mem_byte_enable;
          wdata_n = wdata_in;
        end else if (wd_expire) begin
          state_n = lc3b_types::mem_done;
          rd_n    = 1'b0;
          wr_n    = 1'b0;
          terr_n  = 1'b1;
        end else begin
          cnt_n = cnt_sat;
        end
      end

      mem_acc: begin
        if (dmem_resp) begin
          state_n = lc3b_types::mem_done;
          rd_n    = 1'b0;
          wr_n    = 1'b0;
          if (dmem_read) rdata_n = dmem_rdata;
        end else if (wd_expire) begin
          state_n = lc3b_types::mem_done;
          rd_n    = 1'b0;
          wr_n    = 1'b0;
          terr_n  = 1'b1;
        end else begin
          cnt_n = cnt_sat;
        end
      end

      default: begin
        state_n = mem_idle;
      end
    endcase
  end

  // State, memory-port and status registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state            <= mem_idle;
      dmem_read        <= 1'b0;
      dmem_write       <= 1'b0;
      dmem_address     <= '0;
      dmem_wdata       <= '0;
      dmem_byte_enable <= 2'b11;
      mem_rdata_out    <= '0;
      timeout_err      <= 1'b0;
      cnt              <= '0;
    end else begin
      state            <= state_n;
      dmem_read        <= rd_n;
      dmem_write       <= wr_n;
      dmem_address     <= addr_n;
      dmem_wdata       <= wdata_n;
      dmem_byte_enable <= be_n;
      mem_rdata_out    <= rdata_n;
      timeout_err      <= terr_n;
      cnt              <= cnt_n;
    end
  end

endmodule
